// File: rtl/decode_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_stage_if                                                 |
// | Desc     : Fetch / regfile / writeback / execute signal bundle for decode. |
// |            DECODE_PERF_CNT_EN adds the perf_instr / perf_stall counters.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface decode_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic              if_valid;
  logic              if_ready;
  logic [DATA_W-1:0] if_instr;
  logic [DATA_W-1:0] if_pc;

  logic [ADDR_W-1:0] rf_readadd0;
  logic [ADDR_W-1:0] rf_readadd1;
  logic [DATA_W-1:0] rf_readdata0;
  logic [DATA_W-1:0] rf_readdata1;

  logic              wb_writeenable;
  logic [ADDR_W-1:0] wb_writeadd;
  logic [DATA_W-1:0] wb_writedata;

  logic              flush;
  logic              ex_ready;
  logic              ex_valid;
  logic [DATA_W-1:0] ex_pc;
  logic [DATA_W-1:0] ex_op0;
  logic [DATA_W-1:0] ex_op1;
  logic [DATA_W-1:0] ex_imm;
  logic [ADDR_W-1:0] ex_dest;
  logic [5:0]        ex_opcode;
  logic [5:0]        ex_funct;
  logic              ex_memread;
  logic              ex_regwrite;
`ifdef DECODE_PERF_CNT_EN
  logic [31:0]       perf_instr;
  logic [31:0]       perf_stall;
`endif

  // Decode stage side
  modport slave (
`ifdef DECODE_PERF_CNT_EN
    output perf_instr, perf_stall,
`endif
    input  if_valid, if_instr, if_pc,
    output if_ready,
    output rf_readadd0, rf_readadd1,
    input  rf_readdata0, rf_readdata1,
    input  wb_writeenable, wb_writeadd, wb_writedata,
    input  flush, ex_ready,
    output ex_valid, ex_pc, ex_op0, ex_op1, ex_imm, ex_dest,
    output ex_opcode, ex_funct, ex_memread, ex_regwrite
  );

  // Surrounding pipeline side
  modport master (
`ifdef DECODE_PERF_CNT_EN
    input  perf_instr, perf_stall,
`endif
    output if_valid, if_instr, if_pc,
    input  if_ready,
    input  rf_readadd0, rf_readadd1,
    output rf_readdata0, rf_readdata1,
    output wb_writeenable, wb_writeadd, wb_writedata,
    output flush, ex_ready,
    input  ex_valid, ex_pc, ex_op0, ex_op1, ex_imm, ex_dest,
    input  ex_opcode, ex_funct, ex_memread, ex_regwrite
  );
endinterface
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : decode_stage                                                    |
// | Desc     : MIPS-style ID stage: regfile read, WB bypass, load-use stall    |
// |            and ID/EX register. DECODE_PERF_CNT_EN enables perf counters.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module decode_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  wire            clk,
  input  wire            rst,
  decode_stage_if.slave  bus
);
  localparam logic [5:0] c_op_rtype = 6'h00;
  localparam logic [5:0] c_op_j     = 6'h02;
  localparam logic [5:0] c_op_jal   = 6'h03;
  localparam logic [5:0] c_op_beq   = 6'h04;
  localparam logic [5:0] c_op_bne   = 6'h05;
  localparam logic [5:0] c_op_andi  = 6'h0C;
  localparam logic [5:0] c_op_ori   = 6'h0D;
  localparam logic [5:0] c_op_xori  = 6'h0E;
  localparam logic [5:0] c_op_lui   = 6'h0F;
  localparam logic [5:0] c_op_lw    = 6'h23;
  localparam logic [5:0] c_op_sw    = 6'h2B;

  logic [5:0]        w_opcode;
  logic [ADDR_W-1:0] w_rs;
  logic [ADDR_W-1:0] w_rt;
  logic [ADDR_W-1:0] w_rd;
  logic [15:0]       w_imm16;
  logic [DATA_W-1:0] w_op0;
  logic [DATA_W-1:0] w_op1;
  logic [DATA_W-1:0] w_imm;
  logic [ADDR_W-1:0] w_dest;
  logic              w_regwrite;
  logic              w_memread;
  logic              w_rt_src;
  logic              w_hazard;
  logic              w_ready;
  logic              w_accept;

  logic              r_ex_valid;
  logic [DATA_W-1:0] r_ex_pc;
  logic [DATA_W-1:0] r_ex_op0;
  logic [DATA_W-1:0] r_ex_op1;
  logic [DATA_W-1:0] r_ex_imm;
  logic [ADDR_W-1:0] r_ex_dest;
  logic [5:0]        r_ex_opcode;
  logic [5:0]        r_ex_funct;
  logic              r_ex_memread;
  logic              r_ex_regwrite;
  logic [ADDR_W-1:0] r_ex_rs;
  logic [ADDR_W-1:0] r_ex_rt;

  assign w_opcode = bus.if_instr[31:26];
  assign w_rs     = bus.if_instr[25:21];
  assign w_rt     = bus.if_instr[20:16];
  assign w_rd     = bus.if_instr[15:11];
  assign w_imm16  = bus.if_instr[15:0];

  assign bus.rf_readadd0 = w_rs;
  assign bus.rf_readadd1 = w_rt;

  // The regfile writes at the same edge we sample, so a WB hit must be forwarded
  always_comb begin
    w_op0 = bus.rf_readdata0;
    if (w_rs == '0)
      w_op0 = '0;
    else if (bus.wb_writeenable && (bus.wb_writeadd == w_rs))
      w_op0 = bus.wb_writedata;
  end

  always_comb begin
    w_op1 = bus.rf_readdata1;
    if (w_rt == '0)
      w_op1 = '0;
    else if (bus.wb_writeenable && (bus.wb_writeadd == w_rt))
      w_op1 = bus.wb_writedata;
  end

  always_comb begin
    w_dest     = w_rt;
    w_regwrite = (w_rt != '0);
    w_memread  = 1'b0;
    w_rt_src   = 1'b0;
    case (w_opcode)
      c_op_rtype: begin
        w_dest     = w_rd;
        w_regwrite = (w_rd != '0);
        w_rt_src   = 1'b1;
      end
      c_op_lw:  w_memread = 1'b1;
      c_op_sw, c_op_beq, c_op_bne: begin
        w_regwrite = 1'b0;
        w_rt_src   = 1'b1;
      end
      c_op_j:   w_regwrite = 1'b0;
      c_op_jal: begin
        w_dest     = {ADDR_W{1'b1}};
        w_regwrite = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_imm = {{(DATA_W-16){w_imm16[15]}}, w_imm16};
    case (w_opcode)
      c_op_andi, c_op_ori, c_op_xori: w_imm = {{(DATA_W-16){1'b0}}, w_imm16};
      c_op_lui:                       w_imm = {w_imm16, {(DATA_W-16){1'b0}}};
      default: ;
    endcase
  end

  assign w_hazard = bus.if_valid && r_ex_valid && r_ex_memread && (r_ex_dest != '0) &&
                    ((r_ex_dest == w_rs) || (w_rt_src && (r_ex_dest == w_rt)));
  assign w_ready  = rst && ((((!r_ex_valid) || bus.ex_ready) && !w_hazard) || bus.flush);
  assign w_accept = bus.if_valid && w_ready;
  assign bus.if_ready = w_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_op0      <= '0;
      r_ex_op1      <= '0;
      r_ex_imm      <= '0;
      r_ex_dest     <= '0;
      r_ex_opcode   <= '0;
      r_ex_funct    <= '0;
      r_ex_memread  <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_rs       <= '0;
      r_ex_rt       <= '0;
    end else if (bus.flush) begin
      r_ex_valid <= 1'b0;
    end else if (w_accept) begin
      r_ex_valid    <= 1'b1;
      r_ex_pc       <= bus.if_pc;
      r_ex_op0      <= w_op0;
      r_ex_op1      <= w_op1;
      r_ex_imm      <= w_imm;
      r_ex_dest     <= w_dest;
      r_ex_opcode   <= w_opcode;
      r_ex_funct    <= bus.if_instr[5:0];
      r_ex_memread  <= w_memread;
      r_ex_regwrite <= w_regwrite;
      r_ex_rs       <= w_rs;
      r_ex_rt       <= w_rt;
    end else if (!r_ex_valid || bus.ex_ready) begin
      r_ex_valid <= 1'b0;
    end else if (bus.wb_writeenable && (bus.wb_writeadd != '0)) begin
      // Stalled instruction keeps tracking writeback so its operands never go stale
      if (bus.wb_writeadd == r_ex_rs)
        r_ex_op0 <= bus.wb_writedata;
      if (bus.wb_writeadd == r_ex_rt)
        r_ex_op1 <= bus.wb_writedata;
    end
  end

  assign bus.ex_valid    = r_ex_valid;
  assign bus.ex_pc       = r_ex_pc;
  assign bus.ex_op0      = r_ex_op0;
  assign bus.ex_op1      = r_ex_op1;
  assign bus.ex_imm      = r_ex_imm;
  assign bus.ex_dest     = r_ex_dest;
  assign bus.ex_opcode   = r_ex_opcode;
  assign bus.ex_funct    = r_ex_funct;
  assign bus.ex_memread  = r_ex_memread;
  assign bus.ex_regwrite = r_ex_regwrite;

`ifdef DECODE_PERF_CNT_EN
  logic [31:0] r_perf_instr;
  logic [31:0] r_perf_stall;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_perf_instr <= '0;
      r_perf_stall <= '0;
    end else if (!bus.flush) begin
      if (w_accept)
        r_perf_instr <= r_perf_instr + 32'd1;
      if (w_hazard && bus.ex_ready)
        r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign bus.perf_instr = r_perf_instr;
  assign bus.perf_stall = r_perf_stall;
`endif
endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// Testbench for decode_stage: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model.
module tb_decode_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op0;
    logic [31:0] op1;
    logic [31:0] imm;
    logic [4:0]  dest;
    logic [5:0]  opc;
    logic [5:0]  fn;
    logic        mr;
    logic        rw;
  } ex_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  decode_stage_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  decode_stage #(.DATA_W(DW), .ADDR_W(AW)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] regs [32];
  assign bus.rf_readdata0 = regs[bus.if_instr[25:21]];
  assign bus.rf_readdata1 = regs[bus.if_instr[20:16]];

  int          checks = 0;
  int          errors = 0;
  logic        m_valid;
  ex_t         m;
  logic [4:0]  m_rs, m_rt;
  logic [31:0] m_pi, m_ps;
  logic        rdy_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (bus.wb_writeenable && bus.wb_writeadd == r) return bus.wb_writedata;
    return regs[r];
  endfunction

  function automatic ex_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    ex_t e;
    logic [5:0]  op;
    logic [4:0]  rs, rt, rd;
    logic [31:0] i16;
    op  = ins[31:26];
    rs  = ins[25:21];
    rt  = ins[20:16];
    rd  = ins[15:11];
    i16 = {16'd0, ins[15:0]};
    e.pc  = pc;
    e.op0 = opnd(rs);
    e.op1 = opnd(rt);
    e.opc = op;
    e.fn  = ins[5:0];
    if (op == 6'd12 || op == 6'd13 || op == 6'd14) e.imm = i16;
    else if (op == 6'd15)                          e.imm = i16 * 32'd65536;
    else e.imm = (i16 >= 32'd32768) ? i16 + 32'hFFFF0000 : i16;
    e.mr = (op == 6'd35);
    if (op == 6'd0) begin
      e.dest = rd;
      e.rw   = (rd != 5'd0);
    end else if (op == 6'd3) begin
      e.dest = 5'd31;
      e.rw   = 1'b1;
    end else begin
      e.dest = rt;
      e.rw   = !(op == 6'd43 || op == 6'd4 || op == 6'd5 || op == 6'd2) && (rt != 5'd0);
    end
    return e;
  endfunction

  function automatic logic ref_hazard();
    logic [5:0] op;
    logic [4:0] rs, rt;
    logic       rt_src;
    op = bus.if_instr[31:26];
    rs = bus.if_instr[25:21];
    rt = bus.if_instr[20:16];
    rt_src = (op == 6'd0) || (op == 6'd43) || (op == 6'd4) || (op == 6'd5);
    return bus.if_valid && m_valid && m.mr && (m.dest != 5'd0) &&
           ((m.dest == rs) || (rt_src && m.dest == rt));
  endfunction

  task automatic chk_out();
    chk("ex_valid", {31'd0, bus.ex_valid}, {31'd0, m_valid});
    chk("ex_pc", bus.ex_pc, m.pc);
    chk("ex_op0", bus.ex_op0, m.op0);
    chk("ex_op1", bus.ex_op1, m.op1);
    chk("ex_imm", bus.ex_imm, m.imm);
    chk("ex_dest", {27'd0, bus.ex_dest}, {27'd0, m.dest});
    chk("ex_ctl", {18'd0, bus.ex_opcode, bus.ex_funct, bus.ex_memread, bus.ex_regwrite},
                  {18'd0, m.opc, m.fn, m.mr, m.rw});
`ifdef DECODE_PERF_CNT_EN
    chk("perf_instr", bus.perf_instr, m_pi);
    chk("perf_stall", bus.perf_stall, m_ps);
`endif
  endtask

  // One clock: check if_ready, advance the model over the edge, then check outputs.
  task automatic cycle();
    logic haz, exp_rdy;
    ex_t  nxt;
    #1;
    haz     = ref_hazard();
    exp_rdy = rst && ((((!m_valid) || bus.ex_ready) && !haz) || bus.flush);
    rdy_seen = bus.if_ready;
    chk("if_ready", {31'd0, bus.if_ready}, {31'd0, exp_rdy});
    nxt = ref_decode(bus.if_instr, bus.if_pc);
    @(posedge clk);
    #1;
    if (!rst) begin
      m_valid = 1'b0; m = '0; m_rs = '0; m_rt = '0; m_pi = '0; m_ps = '0;
    end else if (bus.flush) begin
      m_valid = 1'b0;
    end else if (bus.if_valid && exp_rdy) begin
      m = nxt; m_valid = 1'b1; m_pi = m_pi + 32'd1;
      m_rs = bus.if_instr[25:21]; m_rt = bus.if_instr[20:16];
    end else if (!m_valid || bus.ex_ready) begin
      if (haz && bus.ex_ready) m_ps = m_ps + 32'd1;
      m_valid = 1'b0;
    end else if (bus.wb_writeenable && bus.wb_writeadd != 5'd0) begin
      if (bus.wb_writeadd == m_rs) m.op0 = bus.wb_writedata;
      if (bus.wb_writeadd == m_rt) m.op1 = bus.wb_writedata;
    end
    if (bus.wb_writeenable && bus.wb_writeadd != 5'd0) regs[bus.wb_writeadd] = bus.wb_writedata;
    @(negedge clk);
    chk_out();
  endtask

  function automatic logic [31:0] rand_instr();
    logic [5:0] op;
    case ($urandom_range(0, 11))
      0:       op = 6'h00;
      1, 2:    op = 6'h23;
      3:       op = 6'h2B;
      4:       op = 6'h04;
      5:       op = 6'h05;
      6:       op = 6'h02;
      7:       op = 6'h03;
      8:       op = 6'h0C;
      9:       op = 6'h0D;
      10:      op = 6'h0F;
      default: op = 6'h08;
    endcase
    return {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom)};
  endfunction

  initial begin
    logic        any_rdy;
    logic [31:0] pi_before;
    m_valid = 1'b0; m = '0; m_rs = '0; m_rt = '0; m_pi = '0; m_ps = '0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    regs[0] = 32'd0;
    regs[9] = 32'h11;
    bus.if_valid = 1'b1; bus.if_instr = 32'h20080005; bus.if_pc = 32'h100;
    bus.wb_writeenable = 1'b0; bus.wb_writeadd = '0; bus.wb_writedata = '0;
    bus.flush = 1'b0; bus.ex_ready = 1'b1;

    // Reset held two cycles with a beat offered
    rst = 1'b0;
    cycle();
    chk("t1_ready", {31'd0, rdy_seen}, 32'd0);
    cycle();
    chk("t1_ready2", {31'd0, rdy_seen}, 32'd0);
    chk("t1_valid", {31'd0, bus.ex_valid}, 32'd0);
    chk("t1_fields", bus.ex_pc | bus.ex_op0 | bus.ex_op1 | bus.ex_imm, 32'd0);

    // addi $8,$0,5
    rst = 1'b1;
    cycle();
    chk("t2_valid", {31'd0, bus.ex_valid}, 32'd1);
    chk("t2_dest", {27'd0, bus.ex_dest}, 32'd8);
    chk("t2_imm", bus.ex_imm, 32'd5);
    chk("t2_op0", bus.ex_op0, 32'd0);
    chk("t2_rw", {31'd0, bus.ex_regwrite}, 32'd1);

    // add $3,$9,$9 with same-cycle writeback of r9
    bus.if_instr = 32'h01291820; bus.if_pc = 32'h104;
    bus.wb_writeenable = 1'b1; bus.wb_writeadd = 5'd9; bus.wb_writedata = 32'hABCD;
    cycle();
    bus.wb_writeenable = 1'b0;
    chk("t3_op0", bus.ex_op0, 32'hABCD);
    chk("t3_op1", bus.ex_op1, 32'hABCD);

    // lw $9,0($10) then add $11,$9,$9: one bubble
    bus.if_instr = 32'h8D490000; bus.if_pc = 32'h108;
    cycle();
    bus.if_instr = 32'h01295820; bus.if_pc = 32'h10C;
    cycle();
    chk("t4_stall_rdy", {31'd0, rdy_seen}, 32'd0);
    chk("t4_bubble", {31'd0, bus.ex_valid}, 32'd0);
    cycle();
    chk("t4_rdy", {31'd0, rdy_seen}, 32'd1);
    chk("t4_dest", {27'd0, bus.ex_dest}, 32'd11);
`ifdef DECODE_PERF_CNT_EN
    chk("t4_perf_stall", bus.perf_stall, 32'd1);
`endif

    // Hold the add for 3 cycles; r9 written mid-hold
    bus.ex_ready = 1'b0;
    bus.if_instr = 32'h34030009; bus.if_pc = 32'h110;
    any_rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bus.wb_writeenable = (k == 1); bus.wb_writeadd = 5'd9; bus.wb_writedata = 32'h55;
      cycle();
      any_rdy = any_rdy | rdy_seen;
    end
    bus.wb_writeenable = 1'b0;
    chk("t5_rdy", {31'd0, any_rdy}, 32'd0);
    chk("t5_op0", bus.ex_op0, 32'h55);
    chk("t5_dest", {27'd0, bus.ex_dest}, 32'd11);
    chk("t5_pc", bus.ex_pc, 32'h10C);

    // Flush with a beat offered
    bus.ex_ready = 1'b1; bus.flush = 1'b1;
    bus.if_instr = 32'h34020007; bus.if_pc = 32'h200;
    pi_before = m_pi;
    cycle();
    bus.flush = 1'b0;
    chk("t6_rdy", {31'd0, rdy_seen}, 32'd1);
    chk("t6_valid", {31'd0, bus.ex_valid}, 32'd0);
`ifdef DECODE_PERF_CNT_EN
    chk("t6_perf_instr", bus.perf_instr, pi_before);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      rst                = ($urandom_range(0, 63) != 0);
      bus.flush          = ($urandom_range(0, 15) == 0);
      bus.if_valid       = ($urandom_range(0, 3) != 0);
      bus.if_instr       = rand_instr();
      bus.if_pc          = $urandom;
      bus.ex_ready       = ($urandom_range(0, 3) != 0);
      bus.wb_writeenable = ($urandom_range(0, 1) != 0);
      bus.wb_writeadd    = 5'($urandom_range(0, 7));
      bus.wb_writedata   = $urandom;
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
